// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
// Branch codes, fetch FSM encoding and default PC arithmetic steps.
package pc_fetch_sequencer_pkg;

    localparam logic [10:0] ALU_B  = 11'd31;
    localparam logic [10:0] ALU_BL = 11'd32;

    localparam logic [31:0] DEF_PC_STEP   = 32'd4;
    localparam logic [31:0] DEF_BR_BIAS   = 32'd8;
    localparam logic [31:0] DEF_LINK_STEP = 32'd4;

    typedef enum logic {
        FETCH  = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

    function automatic logic is_branch(input logic [10:0] code);
        return (code == ALU_B) || (code == ALU_BL);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_branch_target_calc.sv
// Branch target and link value from the executing instruction.
// Target = ex_pc + sign-extended word offset * 4 + pipeline bias, mod 2^32.
module branch_target_calc
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] P_BR_BIAS   = DEF_BR_BIAS,
    parameter logic [31:0] P_LINK_STEP = DEF_LINK_STEP
) (
    input  logic [31:0] i_ex_pc,
    input  logic [23:0] i_br_address,
    output logic [31:0] o_target,
    output logic [31:0] o_link
);

    logic [31:0] w_offset;

    assign w_offset = {{6{i_br_address[23]}}, i_br_address, 2'b00};
    assign o_target = i_ex_pc + w_offset + P_BR_BIAS;
    assign o_link   = i_ex_pc + P_LINK_STEP;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: sequences fetch, buffers one word for decode,
// resolves taken B/BL with squash of stale fetches and the r14 link write.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter logic [31:0] BR_BIAS  = DEF_BR_BIAS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_ex_valid,
    input  logic [10:0] i_ex_alu_code,
    input  logic [23:0] i_ex_br_address,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_execute,
    output logic        o_redirect,
    output logic        o_ex_stall,
    output logic        o_lr_we,
    output logic [31:0] o_lr_data,
    input  logic        i_lr_ack
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_sq_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_lr_data;
    logic        r_valid;
    logic        r_pend;
    logic        r_active;
    logic        r_redirect;
    logic        r_lr_we;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_take;
    logic        w_fill;
    logic        w_drain;
    logic [31:0] w_target;
    logic [31:0] w_link;

    branch_target_calc #(
        .P_BR_BIAS   (BR_BIAS),
        .P_LINK_STEP (DEF_LINK_STEP)
    ) u_btc (
        .i_ex_pc      (i_ex_pc),
        .i_br_address (i_ex_br_address),
        .o_target     (w_target),
        .o_link       (w_link)
    );

    // A pending link write blocks acceptance of any further branch.
    assign w_take  = i_ex_valid & i_ex_execute
                   & is_branch(i_ex_alu_code) & ~r_lr_we;
    assign w_drain = r_valid & i_instr_ready;
    assign w_fill  = w_req & i_imem_ack & (r_state == FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FETCH: begin
                if (w_take && w_req && !i_imem_ack) begin
                    w_state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                if (i_imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    // A raised request is held by r_pend, so it never depends on
    // i_instr_ready once the memory has seen it.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        unique case (r_state)
            FETCH: begin
                w_req = r_pend | (r_active & (~r_valid | i_instr_ready));
            end
            SQUASH: begin
                w_req  = 1'b1;
                w_addr = r_sq_addr;
            end
            default: begin
                w_req  = 1'b0;
                w_addr = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_sq_addr  <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_pend     <= 1'b0;
            r_active   <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_active   <= 1'b1;
            r_redirect <= w_take;
            r_pend     <= w_req & ~i_imem_ack;
            r_sq_addr  <= w_addr;
            if (w_take) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
            end else if (w_fill) begin
                r_instr    <= i_imem_rdata;
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
                r_pc       <= r_pc + PC_STEP;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lr_we   <= 1'b0;
            r_lr_data <= '0;
        end else if (w_take && (i_ex_alu_code == ALU_BL)) begin
            r_lr_we   <= 1'b1;
            r_lr_data <= w_link;
        end else if (i_lr_ack) begin
            r_lr_we <= 1'b0;
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = w_addr;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_redirect    = r_redirect;
    assign o_ex_stall    = r_lr_we;
    assign o_lr_we       = r_lr_we;
    assign o_lr_data     = r_lr_data;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level fetch model.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        i_ex_valid = 1'b0;
    logic [10:0] i_ex_alu_code = '0;
    logic [23:0] i_ex_br_address = '0;
    logic [31:0] i_ex_pc = '0;
    logic        i_ex_execute = 1'b0;
    logic        o_redirect;
    logic        o_ex_stall;
    logic        o_lr_we;
    logic [31:0] o_lr_data;
    logic        i_lr_ack = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_rdata    (i_imem_rdata),
        .o_instr_valid   (o_instr_valid),
        .o_instr         (o_instr),
        .o_instr_pc      (o_instr_pc),
        .i_instr_ready   (i_instr_ready),
        .i_ex_valid      (i_ex_valid),
        .i_ex_alu_code   (i_ex_alu_code),
        .i_ex_br_address (i_ex_br_address),
        .i_ex_pc         (i_ex_pc),
        .i_ex_execute    (i_ex_execute),
        .o_redirect      (o_redirect),
        .o_ex_stall      (o_ex_stall),
        .o_lr_we         (o_lr_we),
        .o_lr_data       (o_lr_data),
        .i_lr_ack        (i_lr_ack)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: next fetch pc, one-slot buffer, in-flight request, stale flag.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_pend;
    logic [31:0] m_fly;
    logic        m_stale;
    logic        m_active;
    logic        m_redir;
    logic        m_lr_we;
    logic [31:0] m_lr_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tgt(input logic [31:0] pc,
                                        input logic [23:0] br);
        int off;
        off = int'(br);
        if (br[23]) off = off - (1 << 24);
        return pc + 32'(off * 4) + 32'd8;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_valid = 0; m_instr = '0; m_ipc = '0;
        m_pend = 0; m_fly = '0; m_stale = 0; m_active = 0;
        m_redir = 0; m_lr_we = 0; m_lr_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        i_imem_ack = 0; i_instr_ready = 0; i_ex_valid = 0;
        i_ex_execute = 0; i_lr_ack = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        chk("rst_req", {31'd0, o_imem_req}, 0);
        chk("rst_addr", o_imem_addr, 0);
        chk("rst_valid", {31'd0, o_instr_valid}, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_ipc", o_instr_pc, 0);
        chk("rst_redir", {31'd0, o_redirect}, 0);
        chk("rst_stall", {31'd0, o_ex_stall}, 0);
        chk("rst_lrwe", {31'd0, o_lr_we}, 0);
        chk("rst_lrdata", o_lr_data, 0);
    endtask

    task automatic step(input logic rdy, input logic ackd,
                        input logic [31:0] rd, input logic exv,
                        input logic exe, input logic [10:0] code,
                        input logic [23:0] br, input logic [31:0] expc,
                        input logic lrack);
        logic        req_e;
        logic        ack;
        logic        take;
        logic [31:0] addr_e;
        req_e  = m_pend | (m_active & !m_stale & (!m_valid | rdy));
        addr_e = m_pend ? m_fly : m_pc;
        ack    = ackd & req_e;
        i_instr_ready   = rdy;
        i_imem_ack      = ack;
        i_imem_rdata    = rd;
        i_ex_valid      = exv;
        i_ex_execute    = exe;
        i_ex_alu_code   = code;
        i_ex_br_address = br;
        i_ex_pc         = expc;
        i_lr_ack        = lrack & m_lr_we;
        @(negedge clk);
        chk("req", {31'd0, o_imem_req}, {31'd0, req_e});
        chk("addr", o_imem_addr, addr_e);
        chk("valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("instr", o_instr, m_instr);
            chk("ipc", o_instr_pc, m_ipc);
        end
        chk("redir", {31'd0, o_redirect}, {31'd0, m_redir});
        chk("stall", {31'd0, o_ex_stall}, {31'd0, m_lr_we});
        chk("lrwe", {31'd0, o_lr_we}, {31'd0, m_lr_we});
        if (m_lr_we) chk("lrdata", o_lr_data, m_lr_data);
        take = exv & exe & (code == 11'd31 || code == 11'd32) & !m_lr_we;
        if (ack) begin
            if (m_stale) begin
                m_stale = 0;
            end else if (!take) begin
                m_valid = 1; m_instr = rd; m_ipc = addr_e;
                m_pc = m_pc + 32'd4;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (take) begin
            m_pc = tgt(expc, br);
            m_valid = 0;
            if (req_e && !ack) m_stale = 1;
        end
        m_redir = take;
        if (take && code == 11'd32) begin
            m_lr_we = 1; m_lr_data = expc + 32'd4;
        end else if (lrack && m_lr_we) begin
            m_lr_we = 0;
        end
        m_fly = addr_e;
        m_pend = req_e & !ack;
        m_active = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic rdy, input logic ackd,
                       input logic [31:0] rd, input logic lrack);
        step(rdy, ackd, rd, 0, 0, 11'd0, 24'd0, 32'd0, lrack);
    endtask

    initial begin
        logic [10:0] code;
        logic [23:0] br;
        int r;
        model_reset();
        do_reset();
        nop(1, 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", o_imem_addr, 32'(i * 4));
            nop(1, 1, 32'hA000_0000 + 32'(i), 0);
            chk("t1_ipc", o_instr_pc, 32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            nop(0, 1, 32'h5555_5555, 0);
            chk("t2_instr", o_instr, 32'hA000_0003);
        end
        nop(1, 1, 32'hB000_0000, 0);
        chk("t2_ipc", o_instr_pc, 32'h10);
        chk("t2_word", o_instr, 32'hB000_0000);
        step(1, 1, 32'h1, 1, 1, 11'd31, 24'h000010, 32'h100, 0);
        chk("t3_redir", {31'd0, o_redirect}, 1);
        chk("t3_addr", o_imem_addr, 32'h148);
        chk("t3_flush", {31'd0, o_instr_valid}, 0);
        nop(1, 1, 32'hC000_0000, 0);
        chk("t3_pulse", {31'd0, o_redirect}, 0);
        chk("t3_ipc", o_instr_pc, 32'h148);
        step(1, 1, 32'h2, 1, 1, 11'd31, 24'hFFFFFE, 32'h20, 0);
        chk("t4_back", o_imem_addr, 32'h20);
        step(1, 1, 32'h3, 1, 1, 11'd31, 24'h000004, 32'hFFFF_FFF0, 0);
        chk("t4_wrap", o_imem_addr, 32'h8);
        step(1, 1, 32'h4, 1, 1, 11'd32, 24'h000001, 32'h200, 0);
        chk("t5_lrwe", {31'd0, o_lr_we}, 1);
        chk("t5_lrdata", o_lr_data, 32'h204);
        chk("t5_stall", {31'd0, o_ex_stall}, 1);
        chk("t5_addr", o_imem_addr, 32'h20C);
        step(1, 1, 32'h5, 1, 1, 11'd31, 24'h000100, 32'h0, 0);
        chk("t5_block", {31'd0, o_redirect}, 0);
        chk("t5_hold1", {31'd0, o_lr_we}, 1);
        nop(1, 1, 32'h6, 0);
        chk("t5_hold2", {31'd0, o_lr_we}, 1);
        nop(1, 1, 32'h7, 1);
        chk("t5_done", {31'd0, o_lr_we}, 0);
        nop(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 1, 1, 11'd31, 24'h000004, 32'h400, 0);
        chk("t6_redir", {31'd0, o_redirect}, 1);
        chk("t6_req", {31'd0, o_imem_req}, 1);
        nop(1, 0, 32'h0, 0);
        chk("t6_novalid", {31'd0, o_instr_valid}, 0);
        nop(1, 1, 32'hDEAD_BEEF, 0);
        chk("t6_drop", {31'd0, o_instr_valid}, 0);
        chk("t6_target", o_imem_addr, 32'h418);
        nop(1, 1, 32'h1234, 0);
        chk("t6_word", o_instr, 32'h1234);
        chk("t6_ipc", o_instr_pc, 32'h418);
        step(1, 1, 32'h8, 1, 0, 11'd31, 24'h000010, 32'h100, 0);
        chk("nt_redir", {31'd0, o_redirect}, 0);
        nop(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 1, 1, 11'd32, 24'h000040, 32'h800, 0);
        do_reset();
        nop(1, 1, 32'h0, 0);
        nop(1, 1, 32'h9, 0);
        chk("sq_rst_ipc", o_instr_pc, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            r = int'($urandom_range(0, 9));
            code = (r < 3) ? 11'd31 : (r < 5) ? 11'd32
                 : 11'($urandom_range(0, 2047));
            br = ($urandom_range(0, 1) == 1)
               ? 24'($urandom_range(0, 64))
               : 24'(-$urandom_range(1, 64));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, code, br, $urandom,
                 $urandom_range(0, 2) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
